shr_frame_rx: RTL and testbench

- Loopback receiver/checker for the shift-register serial link. Sits directly downstream of din_syn: it consumes the clk/din/syn triplet that din_syn drives onto GPIO_0_D[2:0].
- Deserialises each syn-framed burst into a parallel word and flags framing and timeout errors.
- Keeps frame and error counters so the link can be self-checked on the board.

---
 rtl/shr_link_pkg.sv | 15 +
 rtl/shr_frame_rx_sync_edge.sv | 39 +++
 rtl/shr_frame_rx.sv | 238 +++++++++++++++++++++++
 tb/tb_shr_frame_rx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/shr_link_pkg.sv
// Shared definitions for the shift-register serial link.
// Holds the receiver FSM encoding and the default frame/timeout constants,
// so the transmitter (din_syn) and the receiver agree on the frame length.
package shr_link_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DRAIN = 2'd2
    } rx_state_e;

    localparam int FRAME_BITS_DEF  = 16;
    localparam int TIMEOUT_CYC_DEF = 64;

endpackage

// File: rtl/shr_frame_rx_sync_edge.sv
// sync_edge: two-flop synchroniser followed by a history register that
// yields single-cycle rise/fall strobes on the synchronised level.
// Ports:
//   clk   : sampling clock
//   rst_n : asynchronous active-low reset (all flops to 0)
//   d     : asynchronous input
//   lvl   : synchronised level (second flop)
//   rise  : lvl went 0->1 this cycle
//   fall  : lvl went 1->0 this cycle
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign lvl  = s2;
    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/shr_frame_rx.sv
// shr_frame_rx: loopback receiver/checker for the shift-register serial link.
// Deserialises each syn-framed burst (MSB first) into a parallel word and
// keeps frame/error counters plus sticky error flags for on-board checking.
// Ports:
//   clk_in      : system clock, all logic on its rising edge
//   rst_n       : asynchronous active-low reset
//   ser_clk     : serial clock (asynchronous to clk_in)
//   ser_din     : serial data, valid at ser_clk rising edge
//   ser_syn     : frame enable, high for the whole frame
//   clr         : synchronous clear of counters and sticky errors
//   rx_data     : last good frame
//   rx_valid    : one-cycle pulse when rx_data updates
//   rx_busy     : a frame is being shifted in
//   err_len     : sticky, a frame ended with the wrong bit count
//   err_timeout : sticky, a frame was aborted because ser_clk stalled
//   frame_cnt   : good frames received (wraps)
//   err_cnt     : bad frames received (saturates at 255)
module shr_frame_rx
    import shr_link_pkg::*;
#(
    parameter int FRAME_BITS  = FRAME_BITS_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  ser_clk,
    input  logic                  ser_din,
    input  logic                  ser_syn,
    input  logic                  clr,
    output logic [FRAME_BITS-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  rx_busy,
    output logic                  err_len,
    output logic                  err_timeout,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic [7:0]            err_cnt
);

    localparam int BCNT_W = $clog2(FRAME_BITS + 1) + 1;
    localparam int TCNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(FRAME_BITS);
    localparam logic [BCNT_W-1:0] BCNT_SAT  = BCNT_W'(FRAME_BITS + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

    // Bit count stops one past a legal frame so an overlong frame can never
    // wrap back to exactly FRAME_BITS.
    function automatic logic [BCNT_W-1:0] bcnt_inc_sat(input logic [BCNT_W-1:0] v);
        return (v >= BCNT_SAT) ? v : v + BCNT_W'(1);
    endfunction

    function automatic logic [7:0] err_inc_sat(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // ---------------- input synchronisation ----------------
    logic clk_lvl, clk_rise, clk_fall;
    logic syn_lvl, syn_rise, syn_fall;
    logic din_s1, din_s2;

    sync_edge u_sync_clk (
        .clk   (clk_in),
        .rst_n (rst_n),
        .d     (ser_clk),
        .lvl   (clk_lvl),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    sync_edge u_sync_syn (
        .clk   (clk_in),
        .rst_n (rst_n),
        .d     (ser_syn),
        .lvl   (syn_lvl),
        .rise  (syn_rise),
        .fall  (syn_fall)
    );

    // Data gets the same two-flop delay as ser_clk, so din_s2 is the bit
    // that was on the pin when the synchronised clock edge was seen.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
        end else begin
            din_s1 <= ser_din;
            din_s2 <= din_s1;
        end
    end

    // ---------------- start qualification ----------------
    // The synchroniser flops come out of reset at 0, so a syn that is already
    // high at release would look like a rising edge. Frame starts are only
    // accepted once the pipeline has refilled and syn has been seen low.
    logic [1:0] warm_cnt;
    logic       armed;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            warm_cnt <= 2'd0;
            armed    <= 1'b0;
        end else begin
            if (warm_cnt != 2'd2) begin
                warm_cnt <= warm_cnt + 2'd1;
            end
            if (warm_cnt == 2'd2 && !syn_lvl) begin
                armed <= 1'b1;
            end
        end
    end

    // ---------------- frame FSM ----------------
    rx_state_e          state, state_nxt;
    logic [BCNT_W-1:0]  bcnt;
    logic [TCNT_W-1:0]  tcnt;
    logic               start;
    logic               capture;
    logic               frame_ok;
    logic               frame_bad;
    logic               tmo;
    logic               tcnt_inc;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        capture   = 1'b0;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        tmo       = 1'b0;
        tcnt_inc  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (syn_rise && armed) begin
                    state_nxt = ST_SHIFT;
                    start     = 1'b1;
                    capture   = clk_rise;
                end
            end
            ST_SHIFT: begin
                // syn_fall has priority: a clock edge in the closing cycle
                // belongs to no frame.
                if (syn_fall) begin
                    state_nxt = ST_IDLE;
                    if (bcnt == BCNT_FULL) begin
                        frame_ok = 1'b1;
                    end else begin
                        frame_bad = 1'b1;
                    end
                end else if (clk_rise && syn_lvl) begin
                    capture = 1'b1;
                end else if (tcnt == TCNT_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = ST_DRAIN;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (syn_fall) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign rx_busy = (state == ST_SHIFT);

    // ---------------- datapath and counters ----------------
    logic [FRAME_BITS-1:0] shift_reg;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bcnt        <= '0;
            tcnt        <= '0;
            shift_reg   <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (start) begin
                bcnt <= capture ? BCNT_W'(1) : '0;
            end else if (capture) begin
                bcnt <= bcnt_inc_sat(bcnt);
            end

            if (start || capture) begin
                tcnt <= '0;
            end else if (tcnt_inc) begin
                tcnt <= tcnt + TCNT_W'(1);
            end

            if (capture) begin
                shift_reg <= {shift_reg[FRAME_BITS-2:0], din_s2};
            end

            rx_valid <= frame_ok;
            if (frame_ok) begin
                rx_data <= shift_reg;
            end

            if (clr) begin
                frame_cnt   <= '0;
                err_cnt     <= '0;
                err_len     <= 1'b0;
                err_timeout <= 1'b0;
            end else begin
                if (frame_ok) begin
                    frame_cnt <= frame_cnt + CNT_W'(1);
                end
                if (frame_bad || tmo) begin
                    err_cnt <= err_inc_sat(err_cnt);
                end
                if (frame_bad) begin
                    err_len <= 1'b1;
                end
                if (tmo) begin
                    err_timeout <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_shr_frame_rx.sv
// Directed testbench for shr_frame_rx. Serial inputs are driven just after
// the falling edge of clk_in; outputs are sampled on falling edges.
module tb_shr_frame_rx;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        ser_clk;
    logic        ser_din;
    logic        ser_syn;
    logic        clr;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_busy;
    logic        err_len;
    logic        err_timeout;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_mis = 0;
    int vcount = 0;
    logic [15:0] cap [0:63];
    int v0;

    shr_frame_rx #(
        .FRAME_BITS  (16),
        .TIMEOUT_CYC (64),
        .CNT_W       (16)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .ser_clk     (ser_clk),
        .ser_din     (ser_din),
        .ser_syn     (ser_syn),
        .clr         (clr),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .frame_cnt   (frame_cnt),
        .err_cnt     (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    // Records every rx_valid pulse and the word delivered with it.
    always @(negedge clk_in) begin
        if (rx_valid) begin
            cap[vcount[5:0]] = rx_data;
            vcount = vcount + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raises syn, sends n bits MSB first with an 8-cycle serial clock,
    // and returns with ser_clk low and syn still high.
    task automatic send_bits(input logic [31:0] data, input int n);
        ser_syn = 1'b1;
        for (int i = n - 1; i >= 0; i--) begin
            ser_clk = 1'b0;
            ser_din = data[i];
            repeat (4) @(negedge clk_in);
            ser_clk = 1'b1;
            repeat (4) @(negedge clk_in);
        end
        ser_clk = 1'b0;
        repeat (4) @(negedge clk_in);
    endtask

    // Drops syn and checks rx_valid fires exactly 3 edges later (or never).
    task automatic end_frame(input string tag, input logic good, input logic [15:0] exp_data);
        ser_syn = 1'b0;
        @(negedge clk_in);
        chk({tag, "_vld_t1"}, rx_valid, 0);
        @(negedge clk_in);
        chk({tag, "_vld_t2"}, rx_valid, 0);
        @(negedge clk_in);
        chk({tag, "_vld_t3"}, rx_valid, good);
        chk({tag, "_data"}, rx_data, exp_data);
        @(negedge clk_in);
        chk({tag, "_vld_t4"}, rx_valid, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        ser_clk = 1'b0;
        ser_din = 1'b0;
        ser_syn = 1'b0;
        clr     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_in);
        chk("rst_data", rx_data, 0);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_errs", {err_len, err_timeout}, 0);
        chk("rst_fcnt", frame_cnt, 0);
        chk("rst_ecnt", err_cnt, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);

        // Nominal frame 0xA5C3
        send_bits(32'hA5C3, 16);
        chk("nom_busy", rx_busy, 1);
        end_frame("nom", 1'b1, 16'hA5C3);
        chk("nom_fcnt", frame_cnt, 1);
        chk("nom_errs", {err_len, err_timeout}, 0);
        chk("nom_ecnt", err_cnt, 0);
        chk("nom_busy_end", rx_busy, 0);

        // Short (12) and long (20) frames
        send_bits(32'h0ABC, 12);
        end_frame("short", 1'b0, 16'hA5C3);
        chk("short_elen", err_len, 1);
        chk("short_ecnt", err_cnt, 1);
        send_bits(32'hFFFFF, 20);
        end_frame("long", 1'b0, 16'hA5C3);
        chk("long_ecnt", err_cnt, 2);
        chk("long_fcnt", frame_cnt, 1);
        chk("long_vcount", vcount, 1);
        chk("long_etmo", err_timeout, 0);

        // Timeout: 5 bits, then the serial clock stalls with syn high.
        // Last ser_clk rise was driven 8 negedges before send_bits returns.
        send_bits(32'h15, 5);
        repeat (58) @(negedge clk_in);
        chk("tmo_before", err_timeout, 0);
        chk("tmo_busy_before", rx_busy, 1);
        @(negedge clk_in);
        chk("tmo_after", err_timeout, 1);
        chk("tmo_busy_after", rx_busy, 0);
        chk("tmo_ecnt", err_cnt, 3);
        repeat (3) @(negedge clk_in);
        ser_syn = 1'b0;
        repeat (8) @(negedge clk_in);
        chk("drain_ecnt", err_cnt, 3);
        send_bits(32'h1234, 16);
        end_frame("post_tmo", 1'b1, 16'h1234);
        chk("post_tmo_fcnt", frame_cnt, 2);

        // Reset in the middle of a frame
        send_bits(32'h7F, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", rx_data, 0);
        chk("mid_rst_fcnt", frame_cnt, 0);
        chk("mid_rst_ecnt", err_cnt, 0);
        chk("mid_rst_errs", {err_len, err_timeout, rx_busy, rx_valid}, 0);
        @(negedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        v0 = vcount;
        send_bits(32'h1FF, 9);
        ser_syn = 1'b0;
        repeat (8) @(negedge clk_in);
        chk("mid_rst_novalid", vcount - v0, 0);
        chk("mid_rst_noerr", {err_len, err_timeout}, 0);
        chk("mid_rst_noecnt", err_cnt, 0);
        send_bits(32'hFFFF, 16);
        end_frame("ffff", 1'b1, 16'hFFFF);
        chk("ffff_fcnt", frame_cnt, 1);

        // Plain clear while idle
        clr = 1'b1;
        @(negedge clk_in);
        clr = 1'b0;
        chk("clr_fcnt", frame_cnt, 0);
        chk("clr_keep_data", rx_data, 16'hFFFF);

        // Back-to-back frames with a 2-cycle syn gap
        v0 = vcount;
        send_bits(32'h0001, 16);
        ser_syn = 1'b0;
        repeat (2) @(negedge clk_in);
        send_bits(32'h8000, 16);
        ser_syn = 1'b0;
        repeat (6) @(negedge clk_in);
        chk("b2b_count", vcount - v0, 2);
        chk("b2b_word0", cap[v0[5:0]], 16'h0001);
        chk("b2b_word1", cap[6'(v0 + 1)], 16'h8000);
        chk("b2b_fcnt", frame_cnt, 2);
        chk("b2b_ecnt", err_cnt, 0);

        // Error counter saturation: empty frames (syn pulse, no clocks)
        for (int k = 0; k < 260; k++) begin
            ser_syn = 1'b1;
            repeat (3) @(negedge clk_in);
            ser_syn = 1'b0;
            repeat (3) @(negedge clk_in);
        end
        repeat (3) @(negedge clk_in);
        chk("sat_ecnt", err_cnt, 255);
        chk("sat_elen", err_len, 1);
        chk("sat_fcnt", frame_cnt, 2);

        // clr on the same edge as a good frame's completion
        send_bits(32'h5A5A, 16);
        ser_syn = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        clr = 1'b1;
        @(negedge clk_in);
        clr = 1'b0;
        chk("clrev_valid", rx_valid, 1);
        chk("clrev_data", rx_data, 16'h5A5A);
        chk("clrev_fcnt", frame_cnt, 0);
        chk("clrev_ecnt", err_cnt, 0);
        chk("clrev_errs", {err_len, err_timeout}, 0);
        @(negedge clk_in);
        chk("clrev_fcnt_hold", frame_cnt, 0);
        chk("clrev_valid_end", rx_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
